// File: rtl/matrix_mem_pkg.sv
// Shared types and widths for the matrix memory responder and its storage array.
package matrix_mem_pkg;
    localparam int WORD_W = 32;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/matrix_mem_array.sv
// Word storage: one synchronous write port, one registered synchronous read port.
module matrix_mem_array
    import matrix_mem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end
endmodule

// File: rtl/matrix_mem_responder.sv
// Single-outstanding memory responder with fixed completion latency.
// Optional MATRIX_MEM_RESP_RANGE_CHECK_EN adds an error output for out-of-range word indices.
module matrix_mem_responder
    import matrix_mem_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_memory_transaction,
    input  logic              write_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              done_memory_transaction,
    output logic              busy
`ifdef MATRIX_MEM_RESP_RANGE_CHECK_EN
    ,
    output logic              error
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

    state_t            state;
    logic [LAT_W-1:0]  cnt;
    logic              start_p1;
    logic              start_armed;
    logic              accept;
    logic              fire;
    logic              in_range;
    logic              we_p1;
    logic [29:0]       widx_p1;
    logic [WORD_W-1:0] wdata_p1;
    logic              unused_bits;

    // Armed only after start has been seen low since reset, so a start held across reset is not taken.
    assign accept = (state == IDLE) && start_memory_transaction && !start_p1 && start_armed;
    assign fire   = (state == WAIT) && (cnt == '0);

`ifdef MATRIX_MEM_RESP_RANGE_CHECK_EN
    assign in_range = ({2'b00, widx_p1} < 32'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    assign unused_bits = ^{address[1:0], widx_p1};

    // Request capture: data path, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p1    <= write_en;
            widx_p1  <= address[31:2];
            wdata_p1 <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            cnt                     <= '0;
            start_p1                <= 1'b0;
            start_armed             <= 1'b0;
            done_memory_transaction <= 1'b0;
            busy                    <= 1'b0;
`ifdef MATRIX_MEM_RESP_RANGE_CHECK_EN
            error                   <= 1'b0;
`endif
        end else begin
            start_p1                <= start_memory_transaction;
            done_memory_transaction <= 1'b0;
`ifdef MATRIX_MEM_RESP_RANGE_CHECK_EN
            error                   <= 1'b0;
`endif
            if (!start_memory_transaction) begin
                start_armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= WAIT;
                        cnt   <= LAT_LOAD;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state                   <= DONE;
                        done_memory_transaction <= 1'b1;
`ifdef MATRIX_MEM_RESP_RANGE_CHECK_EN
                        error                   <= !in_range;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    matrix_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fire && we_p1 && in_range),
        .wr_addr (widx_p1[AW-1:0]),
        .wr_data (wdata_p1),
        .rd_en   (fire && !we_p1),
        .rd_zero (!in_range),
        .rd_addr (widx_p1[AW-1:0]),
        .rd_data (rdata)
    );
endmodule

// File: tb/tb_matrix_mem_responder.sv
// Self-checking bench for matrix_mem_responder: directed table, corner sequences, random traffic.
module tb_matrix_mem_responder;
    localparam int DEPTH   = 32;
    localparam int LATENCY = 2;
`ifdef MATRIX_MEM_RESP_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        write_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        err_o;

    matrix_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start_memory_transaction (start),
        .write_en                 (write_en),
        .address                  (address),
        .wdata                    (wdata),
        .rdata                    (rdata),
        .done_memory_transaction  (done),
        .busy                     (busy)
`ifdef MATRIX_MEM_RESP_RANGE_CHECK_EN
        ,
        .error                    (err_o)
`endif
    );
`ifndef MATRIX_MEM_RESP_RANGE_CHECK_EN
    assign err_o = 1'b0;
`endif

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: word-addressed array plus the last value shown on rdata.
    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_valid [DEPTH];
    logic [31:0] mdl_rdata = 32'h0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic mdl_apply(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        int slot;
        idx  = int'(addr >> 2);
        slot = idx % DEPTH;
        exp_err = RC && (idx >= DEPTH);
        if (exp_err) begin
            if (!we) mdl_rdata = 32'h0;
        end else if (we) begin
            mdl_mem[slot]   = data;
            mdl_valid[slot] = 1'b1;
        end else begin
            mdl_rdata = mdl_mem[slot];
        end
        exp_rd = mdl_rdata;
    endtask

    // Called at a negedge with start low; returns at a negedge with start low.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_rd, input logic exp_err, input string tag);
        write_en = we;
        address  = addr;
        wdata    = data;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        write_en = $urandom_range(0, 1);
        address  = $urandom;
        wdata    = $urandom;
        for (int c = 0; c <= LATENCY + 1; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("%s done c%0d", tag, c), {31'b0, done}, {31'b0, c == LATENCY});
            check($sformatf("%s busy c%0d", tag, c), {31'b0, busy}, {31'b0, c <= LATENCY});
            check($sformatf("%s err c%0d", tag, c), {31'b0, err_o}, {31'b0, (c == LATENCY) && exp_err});
            if (c >= LATENCY) check($sformatf("%s rdata c%0d", tag, c), rdata, exp_rd);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] erd;
        logic        eerr;
        int          pulses;

        vecs[0] = '{1'b1, 32'h0000_0008, 32'h0000_1234, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_1234, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_000B, 32'h0,         32'h0000_1234, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0011, 32'h0000_1234, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0080, 32'h0000_A5A5, 32'h0000_1234, RC};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         RC ? 32'h0000_0011 : 32'h0000_A5A5, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0080, 32'h0,         RC ? 32'h0000_0000 : 32'h0000_A5A5, RC};
        vecs[7] = '{1'b1, 32'h0000_0004, 32'h5555_AAAA, RC ? 32'h0000_0000 : 32'h0000_A5A5, 1'b0};

        rst = 1'b1; start = 1'b0; write_en = 1'b0; address = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset rdata", rdata, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset err", {31'b0, err_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            mdl_apply(vecs[i].we, vecs[i].addr, vecs[i].data, erd, eerr);
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, vecs[i].exp_err,
                    $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Start held high for 10 cycles: exactly one transaction.
        mdl_apply(1'b0, 32'h0, 32'h0, erd, eerr);
        write_en = 1'b0; address = 32'h0; start = 1'b1;
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("held rdata", rdata, erd);
            end
            if (c == 10) start = 1'b0;
        end
        check("held pulses", pulses, 1);
        check("held busy end", {31'b0, busy}, 32'h0);

        // Second rising start while waiting is ignored.
        write_en = 1'b1; address = 32'h0000_000C; wdata = 32'hCAFE_0001; start = 1'b1;
        mdl_apply(1'b1, 32'h0000_000C, 32'hCAFE_0001, erd, eerr);
        @(posedge clk);
        pulses = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == 1) begin start = 1'b1; wdata = 32'hDEAD_0002; end
            check($sformatf("reedge done c%0d", c), {31'b0, done}, {31'b0, c == LATENCY});
            if (done) pulses++;
        end
        check("reedge pulses", pulses, 1);
        start = 1'b0;
        @(negedge clk);
        mdl_apply(1'b0, 32'h0000_000C, 32'h0, erd, eerr);
        run_txn(1'b0, 32'h0000_000C, 32'h0, erd, eerr, "reedge read");
        @(negedge clk);

        // Reset during WAIT aborts a write of all ones to 0x4.
        write_en = 1'b1; address = 32'h0000_0004; wdata = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        check("abort rdata", rdata, 32'h0);
        check("abort done", {31'b0, done}, 32'h0);
        check("abort busy", {31'b0, busy}, 32'h0);
        mdl_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("abort no done", pulses, 0);
        mdl_apply(1'b0, 32'h0000_0004, 32'h0, erd, eerr);
        run_txn(1'b0, 32'h0000_0004, 32'h0, erd, eerr, "abort read");
        @(negedge clk);

        // Start held across reset release is not accepted until it toggles.
        write_en = 1'b0; address = 32'h0000_0008; start = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_rdata = 32'h0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy || done) pulses++;
        end
        check("held across reset", pulses, 0);
        start = 1'b0;
        @(negedge clk);
        mdl_apply(1'b0, 32'h0000_0008, 32'h0, erd, eerr);
        run_txn(1'b0, 32'h0000_0008, 32'h0, erd, eerr, "post reset read");
        @(negedge clk);

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [31:0] addr;
            logic [31:0] data;
            int          idx;
            idx  = $urandom_range(0, 7);
            we   = $urandom_range(0, 1);
            if (!mdl_valid[idx]) we = 1'b1;
            addr = {($urandom_range(0, 1) == 1 && !RC) ? 25'd1 : 25'd0, idx[4:0], 2'(($urandom))};
            data = $urandom;
            mdl_apply(we, addr, data, erd, eerr);
            run_txn(we, addr, data, erd, eerr, $sformatf("rand%0d", n));
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
